// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, NZCV flag register
// and an iterative multi-cycle multiplier that stalls the front of the pipe.
//
// Ports:
//   clk_i, reset_n_i           clock, async active-low reset
//   alu_control_signal_i       operation (ADD..MUL)
//   alu_input_{1,2}_select_i   operand source (REG_DATA/IMMEDIATE/ACCUMULATOR_IMM)
//   update_flag_i              write NZCV when the result is final
//   reg_{1,2}_source_addr_i    source register numbers
//   reg_{1,2}_data_i           register-file read data
//   immediate_i                immediate from ID/EX
//   accumulator_imm_i          accumulator immediate from ID/EX
//   ex_mem_* / mem_wb_*        forwarding sources (dest, write enable, data)
//   alu_result_o               result to EX/MEM
//   result_valid_o             alu_result_o is final this cycle
//   stall_o                    hold IF/ID and ID/EX, bubble EX/MEM
//   flags_o                    registered {N,Z,C,V}
package execute_pkg;
  typedef enum logic [3:0] {
    ADD, SUB, AND, ORR, EOR, LSL, LSR, ASR, MOV, MUL
  } alu_control_signal;
  typedef enum logic [1:0] {
    REG_DATA, IMMEDIATE, ACCUMULATOR_IMM
  } alu_input_source;
  typedef enum logic {
    NO_UPDATE_FLAG, UPDATE_FLAG
  } update_flag_sig;
  typedef enum logic {
    NO_REG_WRITE, REG_WRITE
  } reg_file_write_sig;
endpackage

module execute_stage
  import execute_pkg::*;
#(
  parameter int WORD               = 32,
  parameter int ADDR_WIDTH         = 4,
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  alu_control_signal     alu_control_signal_i,
  input  alu_input_source       alu_input_1_select_i,
  input  alu_input_source       alu_input_2_select_i,
  input  update_flag_sig        update_flag_i,
  input  logic [ADDR_WIDTH-1:0] reg_1_source_addr_i,
  input  logic [ADDR_WIDTH-1:0] reg_2_source_addr_i,
  input  logic [WORD-1:0]       reg_1_data_i,
  input  logic [WORD-1:0]       reg_2_data_i,
  input  logic [WORD-1:0]       immediate_i,
  input  logic [WORD-1:0]       accumulator_imm_i,
  input  logic [ADDR_WIDTH-1:0] ex_mem_dest_addr_i,
  input  reg_file_write_sig     ex_mem_write_en_i,
  input  logic [WORD-1:0]       ex_mem_result_i,
  input  logic [ADDR_WIDTH-1:0] mem_wb_dest_addr_i,
  input  reg_file_write_sig     mem_wb_write_en_i,
  input  logic [WORD-1:0]       mem_wb_result_i,
  output logic [WORD-1:0]       alu_result_o,
  output logic                  result_valid_o,
  output logic                  stall_o,
  output logic [3:0]            flags_o
);

  localparam int ITER = WORD / MUL_BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_BUSY, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WORD-1:0] fwd_1, fwd_2;
  logic [WORD-1:0] op1, op2;
  logic [WORD-1:0] alu_res;
  logic            c_new, v_new;
  logic [WORD:0]   add_w, sub_w;
  logic [WORD:0]   lsl_w, lsr_w, asr_w;
  logic [7:0]      amt;

  logic [WORD-1:0] mcand_q, mplier_q, acc_q;
  logic [WORD-1:0] pp;
  logic [CW-1:0]   cnt_q;
  logic            is_mul, last_iter;

  // EX/MEM is the younger producer, so it takes priority
  always_comb begin
    fwd_1 = reg_1_data_i;
    if (ex_mem_write_en_i == REG_WRITE &&
        ex_mem_dest_addr_i == reg_1_source_addr_i)
      fwd_1 = ex_mem_result_i;
    else if (mem_wb_write_en_i == REG_WRITE &&
             mem_wb_dest_addr_i == reg_1_source_addr_i)
      fwd_1 = mem_wb_result_i;
  end

  always_comb begin
    fwd_2 = reg_2_data_i;
    if (ex_mem_write_en_i == REG_WRITE &&
        ex_mem_dest_addr_i == reg_2_source_addr_i)
      fwd_2 = ex_mem_result_i;
    else if (mem_wb_write_en_i == REG_WRITE &&
             mem_wb_dest_addr_i == reg_2_source_addr_i)
      fwd_2 = mem_wb_result_i;
  end

  always_comb begin
    op1 = fwd_1;
    unique case (alu_input_1_select_i)
      IMMEDIATE:       op1 = immediate_i;
      ACCUMULATOR_IMM: op1 = accumulator_imm_i;
      default:         op1 = fwd_1;
    endcase
  end

  always_comb begin
    op2 = fwd_2;
    unique case (alu_input_2_select_i)
      IMMEDIATE:       op2 = immediate_i;
      ACCUMULATOR_IMM: op2 = accumulator_imm_i;
      default:         op2 = fwd_2;
    endcase
  end

  // Shifts run one bit wider so the bit shifted out lands in the extra bit;
  // amounts beyond the width naturally flush to zero or sign fill.
  assign amt   = op2[7:0];
  assign add_w = {1'b0, op1} + {1'b0, op2};
  assign sub_w = {1'b0, op1} + {1'b0, ~op2} + {{WORD{1'b0}}, 1'b1};
  assign lsl_w = {1'b0, op1} << amt;
  assign lsr_w = {op1, 1'b0} >> amt;
  assign asr_w = $signed({op1, 1'b0}) >>> amt;

  always_comb begin
    alu_res = '0;
    c_new   = flags_o[1];
    v_new   = flags_o[0];
    unique case (alu_control_signal_i)
      ADD: begin
        alu_res = add_w[WORD-1:0];
        c_new   = add_w[WORD];
        v_new   = (op1[WORD-1] == op2[WORD-1]) &&
                  (alu_res[WORD-1] != op1[WORD-1]);
      end
      SUB: begin
        alu_res = sub_w[WORD-1:0];
        c_new   = sub_w[WORD];
        v_new   = (op1[WORD-1] != op2[WORD-1]) &&
                  (alu_res[WORD-1] != op1[WORD-1]);
      end
      AND: alu_res = op1 & op2;
      ORR: alu_res = op1 | op2;
      EOR: alu_res = op1 ^ op2;
      LSL: begin
        alu_res = lsl_w[WORD-1:0];
        if (amt != 8'd0) c_new = lsl_w[WORD];
      end
      LSR: begin
        alu_res = lsr_w[WORD:1];
        if (amt != 8'd0) c_new = lsr_w[0];
      end
      ASR: begin
        alu_res = asr_w[WORD:1];
        if (amt != 8'd0) c_new = asr_w[0];
      end
      MOV:     alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  assign is_mul    = (alu_control_signal_i == MUL);
  assign last_iter = (cnt_q == CW'(ITER - 1));
  assign pp        = mcand_q * WORD'(mplier_q[MUL_BITS_PER_CYCLE-1:0]);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (is_mul) state_d = S_BUSY;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset gates the handshake outputs so stall drops without a clock edge
  always_comb begin
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    alu_result_o   = alu_res;
    unique case (state_q)
      S_IDLE: begin
        stall_o        = reset_n_i & is_mul;
        result_valid_o = reset_n_i & ~is_mul;
      end
      S_BUSY: begin
        stall_o      = reset_n_i;
        alu_result_o = acc_q;
      end
      S_DONE: begin
        result_valid_o = reset_n_i;
        alu_result_o   = acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_IDLE && is_mul) begin
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_BUSY) begin
      acc_q    <= acc_q + pp;
      mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
      mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // In DONE the op input is still MUL, so C/V default to hold
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      flags_o <= 4'b0000;
    end else if (update_flag_i == UPDATE_FLAG && result_valid_o) begin
      flags_o <= {alu_result_o[WORD-1],
                  alu_result_o == '0,
                  c_new,
                  v_new};
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage consuming the ID/EX pipeline register outputs and producing the ALU result for the EX/MEM register.
- Resolves operand forwarding from EX/MEM and MEM/WB and owns the architectural NZCV flag register.
- Runs MUL as an iterative multi-cycle operation and stalls the front of the pipe with stall_o meanwhile.

Parameters:
- WORD, 32, datapath width.
- ADDR_WIDTH, 4, register address width.
- MUL_BITS_PER_CYCLE, 4, multiplier bits retired per iteration; must divide WORD. Iterations = WORD/MUL_BITS_PER_CYCLE (8 at defaults).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- alu_control_signal_i  in  alu_control_signal  op: ADD, SUB, AND, ORR, EOR, LSL, LSR, ASR, MOV, MUL.
- alu_input_1_select_i, alu_input_2_select_i  in  alu_input_source  REG_DATA, IMMEDIATE or ACCUMULATOR_IMM.
- update_flag_i  in  update_flag_sig  UPDATE_FLAG or NO_UPDATE_FLAG.
- reg_1_source_addr_i, reg_2_source_addr_i  in  ADDR_WIDTH  source register numbers.
- reg_1_data_i, reg_2_data_i  in  WORD  register-file read data.
- immediate_i, accumulator_imm_i  in  WORD  immediates from ID/EX.
- ex_mem_dest_addr_i  in  ADDR_WIDTH  forwarding source 1 destination.
- ex_mem_write_en_i  in  reg_file_write_sig  forwarding source 1 write enable.
- ex_mem_result_i  in  WORD  forwarding source 1 data.
- mem_wb_dest_addr_i  in  ADDR_WIDTH  forwarding source 2 destination.
- mem_wb_write_en_i  in  reg_file_write_sig  forwarding source 2 write enable.
- mem_wb_result_i  in  WORD  forwarding source 2 data.
- alu_result_o  out  WORD  result to EX/MEM.
- result_valid_o  out  1  alu_result_o is final this cycle.
- stall_o  out  1  hold IF/ID and ID/EX and insert a bubble into EX/MEM.
- flags_o  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset (async, reset_n_i=0): flags_o=4'b0000, FSM=IDLE, stall_o=0, multiplier accumulator/counter cleared. alu_result_o is don't-care and result_valid_o=0 while in reset.
- Forwarding per operand with source select REG_DATA:
  - EX/MEM data when ex_mem_write_en_i=REG_WRITE and ex_mem_dest_addr_i matches the source address.
  - Else MEM/WB data under the same rule.
  - Else reg_*_data_i.
  - EX/MEM wins when both match.
- Operand select: IMMEDIATE selects immediate_i; ACCUMULATOR_IMM selects accumulator_imm_i.
- Single-cycle ops are combinational in the same cycle with result_valid_o=1, stall_o=0.
  - Shifts use op2[7:0] as the amount; an amount ≥32 gives 0 for LSL/LSR and a sign fill for ASR.
  - MOV passes op2.
- Flags register on the rising edge when update_flag_i=UPDATE_FLAG and result_valid_o=1.
  - N=result[31], Z=(result==0).
  - ADD: C=carry-out, V=signed overflow. SUB computes op1+~op2+1: C=NOT borrow, V=signed overflow.
  - Logical, MOV and MUL ops update N and Z only; C and V hold. Shifts set C to the last bit shifted out, or hold C when the amount is 0.
- MUL FSM:
  - IDLE: on op==MUL, latch op1/op2 and go to BUSY. stall_o=1 and result_valid_o=0 from this cycle onward.
  - BUSY: each cycle adds op1 × the next MUL_BITS_PER_CYCLE low bits of the multiplier into a WORD-wide accumulator (low 32 bits kept), shifting the multiplicand and multiplier. A counter runs 0..N-1.
  - After N BUSY cycles go to DONE.
  - DONE: one cycle with alu_result_o=product, result_valid_o=1, stall_o=0, flags updated if requested. Then IDLE.
  - Total occupancy is N+2 cycles from MUL arrival to the consuming edge. Forwarding inputs are ignored after latching.
- While stall_o=1, the ID/EX inputs are held stable by upstream logic and this block does not re-sample them.
- Reset mid-MUL aborts to IDLE, drops stall_o immediately (asynchronously) and clears flags.
- Back-to-back MULs: the second is sampled in the cycle after DONE, so there are no lost or duplicated results.

Test Plan:
- Forwarding priority: r3 arrives from EX/MEM=0x11, MEM/WB=0x22, RF=0x33, op ADD with r3+imm 1 -> result 0x12. With EX/MEM write disabled -> 0x23. With neither writing -> 0x34.
- Flags: SUB 0x80000000 - 1 with UPDATE_FLAG -> result 0x7FFFFFFF, NZCV=0011. A following ADD 0xFFFFFFFF+1 with UPDATE_FLAG -> 0, NZCV=0110. AND with NO_UPDATE_FLAG -> flags unchanged.
- Shifts: ASR 0x80000000 by 40 -> 0xFFFFFFFF, C=1. LSL 1 by 0 -> 1, C held.
- MUL: 0x0001_0003 × 0x0000_0005 -> stall_o high 9 cycles, then 0x0005_000F with result_valid_o=1 for exactly 1 cycle. Follow with 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001, Z=0.
- Reset mid-MUL: assert reset_n_i=0 at BUSY iteration 3 -> stall_o=0 and flags_o=0 without waiting for a clock edge. After release, an ADD completes in 1 cycle.
- Back-to-back MUL then ADD using the MUL destination via EX/MEM forwarding -> ADD sees the product; no extra stall beyond the MUL window.
